// File: rtl/sequenciador_medidas.sv
// Measurement sequencer: requests range measurements and declares success after
// N_ACERTOS consecutive in-band results, or failure after MAX_TENTATIVAS attempts.
module sequenciador_medidas #(
    parameter int unsigned INTERVALO      = 3_000_000,
    parameter int unsigned TIMEOUT        = 2_500_000,
    parameter int unsigned N_ACERTOS      = 3,
    parameter int unsigned MAX_TENTATIVAS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pronto,
    input  logic       dentro,
    output logic       medir,
    output logic       acertou,
    output logic       fim,
    output logic       timeout,
    output logic [3:0] db_estado,
    output logic [3:0] db_acertos
);

    localparam int unsigned MAX_CNT = (INTERVALO > TIMEOUT) ? INTERVALO : TIMEOUT;
    localparam int unsigned TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [TW-1:0] FIM_AGUARDA = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] FIM_ESPERA  = TW'(INTERVALO - 1);
    localparam logic [3:0]    ALVO_ACERTOS = 4'(N_ACERTOS);
    localparam logic [3:0]    ALVO_TENT    = 4'(MAX_TENTATIVAS);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        MEDE    = 4'd2,
        AGUARDA = 4'd3,
        AVALIA  = 4'd4,
        ESPERA  = 4'd5,
        ACERTOU = 4'd6,
        FALHA   = 4'd7
    } estado_t;

    estado_t       state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    acertos, acertos_n;
    logic [3:0]    tentativas, tentativas_n;
    logic [3:0]    acertos_upd;
    logic          resultado, resultado_n;
    logic          perdida, perdida_n;
    logic          medir_n, acertou_n, fim_n, timeout_n;

    // State, counters and Moore outputs; outputs follow the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INICIAL;
            timer      <= '0;
            acertos    <= '0;
            tentativas <= '0;
            resultado  <= 1'b0;
            perdida    <= 1'b0;
            medir      <= 1'b0;
            acertou    <= 1'b0;
            fim        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            acertos    <= acertos_n;
            tentativas <= tentativas_n;
            resultado  <= resultado_n;
            perdida    <= perdida_n;
            medir      <= medir_n;
            acertou    <= acertou_n;
            fim        <= fim_n;
            timeout    <= timeout_n;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        acertos_n    = acertos;
        tentativas_n = tentativas;
        resultado_n  = resultado;
        perdida_n    = perdida;
        acertos_upd  = '0;

        case (state)
            INICIAL, ACERTOU, FALHA: begin
                if (iniciar) begin
                    state_n      = PREPARA;
                    acertos_n    = '0;
                    tentativas_n = '0;
                    timer_n      = '0;
                end
            end
            PREPARA: begin
                acertos_n    = '0;
                tentativas_n = '0;
                timer_n      = '0;
                resultado_n  = 1'b0;
                perdida_n    = 1'b0;
                state_n      = MEDE;
            end
            MEDE: begin
                if (tentativas != ALVO_TENT) begin
                    tentativas_n = tentativas + 4'd1;
                end
                timer_n = '0;
                state_n = AGUARDA;
            end
            AGUARDA: begin
                // A completed measurement wins over a simultaneous expiry
                if (pronto) begin
                    resultado_n = dentro;
                    perdida_n   = 1'b0;
                    state_n     = AVALIA;
                end else if (timer == FIM_AGUARDA) begin
                    resultado_n = 1'b0;
                    perdida_n   = 1'b1;
                    state_n     = AVALIA;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            AVALIA: begin
                acertos_upd = (resultado && !perdida) ? acertos + 4'd1 : 4'd0;
                acertos_n   = acertos_upd;
                timer_n     = '0;
                if (acertos_upd == ALVO_ACERTOS) begin
                    state_n = ACERTOU;
                end else if (tentativas == ALVO_TENT) begin
                    state_n = FALHA;
                end else begin
                    state_n = ESPERA;
                end
            end
            ESPERA: begin
                if (timer == FIM_ESPERA) begin
                    timer_n = '0;
                    state_n = MEDE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n = INICIAL;
            end
        endcase

        medir_n   = (state_n == MEDE);
        acertou_n = (state_n == ACERTOU);
        fim_n     = (state_n == ACERTOU) || (state_n == FALHA);
        timeout_n = (state_n == AVALIA) && perdida_n;
    end

    assign db_estado  = state;
    assign db_acertos = acertos;

endmodule

// File: doc/sequenciador_medidas.md
SEQUENCIADOR_MEDIDAS -- requirements
Module: sequenciador_medidas

Interface
REQ-001 Parameter INTERVALO, default 3_000_000, clock cycles spent in ESPERA between attempts (60 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 2_500_000, maximum AGUARDA cycles before an attempt is declared lost.
REQ-003 Parameter N_ACERTOS, default 3, consecutive in-band results required for success (range 1..15).
REQ-004 Parameter MAX_TENTATIVAS, default 8, attempts allowed per sequence (range 1..15, >= N_ACERTOS).
REQ-005 clock  in  1  system clock, 50 MHz, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 iniciar  in  1  start/restart request, sampled high on a rising edge.
REQ-008 pronto  in  1  one-cycle pulse from the range meter marking a completed measurement.
REQ-009 dentro  in  1  meter result is inside the band [lowerL, upperL], valid in the cycle pronto is high.
REQ-010 medir  out  1  one-cycle request pulse to the range meter.
REQ-011 acertou  out  1  level, sequence succeeded.
REQ-012 fim  out  1  level, sequence finished (success or failure).
REQ-013 timeout  out  1  one-cycle flag, current attempt lost.
REQ-014 db_estado  out  4  current state code.
REQ-015 db_acertos  out  4  current consecutive-hit count.

Function
REQ-016 FSM states and db_estado codes SHALL be INICIAL=0, PREPARA=1, MEDE=2, AGUARDA=3, AVALIA=4, ESPERA=5, ACERTOU=6, FALHA=7; codes 8-15 unused, and any unused code SHALL go to INICIAL on the next clock.
REQ-017 INICIAL: all outputs 0 except db_*; iniciar=1 -> PREPARA.
REQ-018 PREPARA (1 cycle): clear acertos, tentativas, timer; acertou=0, fim=0 -> MEDE.
REQ-019 MEDE (1 cycle): medir=1 (Moore), tentativas += 1, timer cleared -> AGUARDA; medir SHALL rise exactly 2 cycles after iniciar is sampled.
REQ-020 AGUARDA: timer increments each cycle from 0; pronto=1 -> AVALIA with dentro latched.
REQ-021 AGUARDA: timer == TIMEOUT-1 with pronto=0 -> AVALIA with latched result forced to miss and lost flag set; AGUARDA lasts at most TIMEOUT cycles.
REQ-022 pronto and timer expiry in the same cycle: pronto SHALL win; the attempt is valid and no timeout is flagged.
REQ-023 AVALIA (1 cycle): timeout=1 iff the attempt was lost; hit -> acertos += 1; miss or lost -> acertos = 0.
REQ-024 AVALIA next-state priority: updated acertos == N_ACERTOS -> ACERTOU; else tentativas == MAX_TENTATIVAS -> FALHA; else -> ESPERA.
REQ-025 ESPERA: exactly INTERVALO cycles (timer reused), then -> MEDE.
REQ-026 ACERTOU: acertou=1, fim=1; FALHA: acertou=0, fim=1; in both states iniciar=1 -> PREPARA.
REQ-027 pronto outside AGUARDA and iniciar outside INICIAL/ACERTOU/FALHA SHALL be ignored.
REQ-028 Timer width SHALL hold max(INTERVALO, TIMEOUT)-1 without wrap; acertos and tentativas are 4 bits and never exceed their limits.

Reset
REQ-029 reset=0 SHALL immediately, without a clock, force state INICIAL, clear all counters and the latched result, and drive medir, acertou, fim, timeout, db_acertos=0 and db_estado=0.
REQ-030 Reset asserted mid-sequence (any state) SHALL abandon the sequence; no medir pulse SHALL follow until a new iniciar.

Verification (INTERVALO=10, TIMEOUT=20, N_ACERTOS=3, MAX_TENTATIVAS=5)
REQ-031 iniciar, then pronto+dentro=1 5 cycles after each medir, 3 times -> exactly 3 medir pulses, each later pulse INTERVALO+1 cycles after the preceding AVALIA cycle; acertou=1, fim=1, db_estado=6, db_acertos=3.
REQ-032 dentro sequence 1,1,0,1,1 -> db_acertos 1,2,0,1,2; after the 5th AVALIA -> FALHA, fim=1, acertou=0, db_estado=7.
REQ-033 No pronto ever -> timeout=1 for one cycle, 21 cycles after each medir; after 5 attempts -> FALHA.
REQ-034 pronto with dentro=1 on timer==19 -> timeout stays 0 and db_acertos increments.
REQ-035 reset pulled low during AGUARDA of the 2nd attempt -> all outputs 0 asynchronously; held idle in INICIAL; next iniciar restarts with db_acertos=0.
REQ-036 From ACERTOU, iniciar=1 -> PREPARA next cycle, acertou and fim drop, new medir 2 cycles after iniciar.
